// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and limits for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_MEM = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  // Wait counter is 4 bits, so at most 15 strobe cycles per access.
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/dmem_wait_counter.sv
// dmem_wait_counter: 4-bit down counter with load and zero flag; times
// how long the memory strobes stay asserted.
module dmem_wait_counter
  import dmem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement only while nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (dec && !zero)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM
// stage and the loader/debug port. IDLE -> ACCESS (WAIT_CYCLES strobe
// cycles) -> DONE (one-cycle Ack). Optional macro DMEM_ARB_RR_EN switches
// arbitration from fixed MEM priority to round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic [31:0] MEM_RData,
  output logic        MEM_Ack,
  output logic        MEM_Stall,
  input  logic        LD_Req,
  input  logic        LD_Write,
  input  logic [31:0] LD_Addr,
  input  logic [31:0] LD_WData,
  output logic [31:0] LD_RData,
  output logic        LD_Ack,
  output logic [31:0] DM_Address,
  output logic [31:0] DM_WriteData,
  output logic        DM_MemWrite,
  output logic        DM_MemRead,
  input  logic [31:0] DM_ReadData
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("dmem_arbiter: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e   state;
  req_id_e  owner;
  req_id_e  win;
  logic     wr;
  logic     any_req;
  logic     cnt_zero;
  logic     sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  assign any_req = MEM_Req | LD_Req;

`ifdef DMEM_ARB_RR_EN
  req_id_e last_grant;

  // On contention, grant whoever was not served last; a lone requester wins.
  always_comb begin
    win = MEM_Req ? REQ_MEM : REQ_LD;
    if (MEM_Req && LD_Req)
      win = (last_grant == REQ_MEM) ? REQ_LD : REQ_MEM;
  end

  // Remember the most recent grant; reset to LD so MEM wins first contention.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                           last_grant <= REQ_LD;
    else if (state == IDLE && any_req) last_grant <= win;
  end
`else
  // Fixed priority: MEM always wins, LD may starve under continuous MEM traffic.
  always_comb begin
    win = MEM_Req ? REQ_MEM : REQ_LD;
  end
`endif

  // Mux the winner's fields for latching at grant.
  always_comb begin
    sel_write = (win == REQ_MEM) ? MEM_Write : LD_Write;
    sel_addr  = (win == REQ_MEM) ? MEM_Addr  : LD_Addr;
    sel_wdata = (win == REQ_MEM) ? MEM_WData : LD_WData;
  end

  dmem_wait_counter u_wait (
    .clk      (Clk),
    .rst      (Rst),
    .load     (state == IDLE && any_req),
    .load_val (WAIT_LOAD),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // Access sequencer: latch at grant, strobe through ACCESS, ack in DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      owner        <= REQ_MEM;
      wr           <= 1'b0;
      DM_Address   <= '0;
      DM_WriteData <= '0;
      DM_MemWrite  <= 1'b0;
      DM_MemRead   <= 1'b0;
      MEM_Ack      <= 1'b0;
      LD_Ack       <= 1'b0;
      MEM_RData    <= '0;
      LD_RData     <= '0;
    end else begin
      MEM_Ack <= 1'b0;
      LD_Ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= win;
            wr           <= sel_write;
            DM_Address   <= sel_addr;
            DM_WriteData <= sel_wdata;
            DM_MemWrite  <= sel_write;
            DM_MemRead   <= ~sel_write;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            DM_MemWrite <= 1'b0;
            DM_MemRead  <= 1'b0;
            if (!wr) begin
              if (owner == REQ_MEM) MEM_RData <= DM_ReadData;
              else                  LD_RData  <= DM_ReadData;
            end
            if (owner == REQ_MEM) MEM_Ack <= 1'b1;
            else                  LD_Ack  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign MEM_Stall = MEM_Req & ~MEM_Ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench; dut1 runs WAIT_CYCLES=1, dut3 runs
// WAIT_CYCLES=3, both on shared stimulus, each with its own memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_write, ld_req, ld_write;
  logic [31:0] mem_addr, mem_wdata, ld_addr, ld_wdata;

  logic [31:0] mem_rdata1, ld_rdata1, dm_addr1, dm_wdata1, dm_rdata1;
  logic        mem_ack1, mem_stall1, ld_ack1, dm_we1, dm_rd1;
  logic [31:0] mem_rdata3, ld_rdata3, dm_addr3, dm_wdata3, dm_rdata3;
  logic        mem_ack3, mem_stall3, ld_ack3, dm_we3, dm_rd3;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .Clk(clk), .Rst(rst),
    .MEM_Req(mem_req), .MEM_Write(mem_write), .MEM_Addr(mem_addr), .MEM_WData(mem_wdata),
    .MEM_RData(mem_rdata1), .MEM_Ack(mem_ack1), .MEM_Stall(mem_stall1),
    .LD_Req(ld_req), .LD_Write(ld_write), .LD_Addr(ld_addr), .LD_WData(ld_wdata),
    .LD_RData(ld_rdata1), .LD_Ack(ld_ack1),
    .DM_Address(dm_addr1), .DM_WriteData(dm_wdata1), .DM_MemWrite(dm_we1),
    .DM_MemRead(dm_rd1), .DM_ReadData(dm_rdata1)
  );

  dmem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .Clk(clk), .Rst(rst),
    .MEM_Req(mem_req), .MEM_Write(mem_write), .MEM_Addr(mem_addr), .MEM_WData(mem_wdata),
    .MEM_RData(mem_rdata3), .MEM_Ack(mem_ack3), .MEM_Stall(mem_stall3),
    .LD_Req(ld_req), .LD_Write(ld_write), .LD_Addr(ld_addr), .LD_WData(ld_wdata),
    .LD_RData(ld_rdata3), .LD_Ack(ld_ack3),
    .DM_Address(dm_addr3), .DM_WriteData(dm_wdata3), .DM_MemWrite(dm_we3),
    .DM_MemRead(dm_rd3), .DM_ReadData(dm_rdata3)
  );

  // Word-addressed memory models, 64 words each.
  always @(posedge clk) if (dm_we1) mem1[dm_addr1[7:2]] <= dm_wdata1;
  always @(posedge clk) if (dm_we3) mem3[dm_addr3[7:2]] <= dm_wdata3;
  assign dm_rdata1 = mem1[dm_addr1[7:2]];
  assign dm_rdata3 = mem3[dm_addr3[7:2]];

  task automatic idle(input int n);
    mem_req = 1'b0; ld_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h10; mem_wdata = 32'h0;
    ld_req = 1'b0; ld_write = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    @(negedge clk);
    n_chk++;
    if ({dm_addr1, dm_wdata1, dm_we1, dm_rd1} !== 66'h0) begin
      n_fail++; $display("FAIL reset_dm: got %h want 0", {dm_addr1, dm_wdata1, dm_we1, dm_rd1});
    end
    n_chk++;
    if ({mem_rdata1, ld_rdata1, mem_ack1, ld_ack1} !== 66'h0) begin
      n_fail++; $display("FAIL reset_resp: got %h want 0", {mem_rdata1, ld_rdata1, mem_ack1, ld_ack1});
    end
    n_chk++;
    if (mem_stall1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall: got %b want 1", mem_stall1);
    end
    mem_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({dm_we1, dm_rd1, mem_ack1, mem_stall1} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {dm_we1, dm_rd1, mem_ack1, mem_stall1});
    end
    idle(2);
  endtask

  task automatic test_store_load;
    // store 0xDEADBEEF @0x10
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if ({dm_we1, dm_rd1, dm_addr1, dm_wdata1, mem_ack1, mem_stall1} !== {2'b10, 32'h10, 32'hDEADBEEF, 2'b01}) begin
      n_fail++; $display("FAIL st_t1: got we%b rd%b a%h d%h ack%b st%b", dm_we1, dm_rd1, dm_addr1, dm_wdata1, mem_ack1, mem_stall1);
    end
    @(negedge clk);
    n_chk++;
    if ({dm_we1, mem_ack1, mem_stall1} !== 3'b010) begin
      n_fail++; $display("FAIL st_t2: got we%b ack%b st%b want 0 1 0", dm_we1, mem_ack1, mem_stall1);
    end
    idle(8);
    n_chk++;
    if (mem1[4] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL st_mem: got %h want deadbeef", mem1[4]);
    end
    // load @0x10
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h10;
    @(negedge clk);
    n_chk++;
    if ({dm_we1, dm_rd1, mem_ack1} !== 3'b010) begin
      n_fail++; $display("FAIL ld_t1: got we%b rd%b ack%b want 0 1 0", dm_we1, dm_rd1, mem_ack1);
    end
    @(negedge clk);
    n_chk++;
    if ({mem_ack1, mem_stall1, dm_rd1, mem_rdata1} !== {3'b100, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL ld_t2: got ack%b st%b rd%b data %h want 1 0 0 deadbeef", mem_ack1, mem_stall1, dm_rd1, mem_rdata1);
    end
    idle(8);
  endtask

  task automatic test_wait3;
    logic exp_rd, exp_ack, exp_st;
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h10;
    #1;
    n_chk++;
    if (mem_stall3 !== 1'b1) begin
      n_fail++; $display("FAIL w3_t0_stall: got %b want 1", mem_stall3);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_rd  = (k <= 3);
      exp_ack = (k == 4);
      exp_st  = (k <= 3);
      n_chk++;
      if ({dm_rd3, dm_we3, mem_ack3, mem_stall3} !== {exp_rd, 1'b0, exp_ack, exp_st}) begin
        n_fail++; $display("FAIL w3_t%0d: got rd%b we%b ack%b st%b want rd%b we0 ack%b st%b",
                           k, dm_rd3, dm_we3, mem_ack3, mem_stall3, exp_rd, exp_ack, exp_st);
      end
      if (k == 4) begin
        n_chk++;
        if (mem_rdata3 !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL w3_rdata: got %h want deadbeef", mem_rdata3);
        end
        mem_req = 1'b0;
      end
    end
    idle(8);
  endtask

  task automatic test_arbitration;
    int grants[4];
    int ng = 0;
    int cyc = 0;
    int exp_g;
    do_reset;
    mem_req = 1'b1; ld_req = 1'b1; mem_write = 1'b0; ld_write = 1'b0;
    mem_addr = 32'h10; ld_addr = 32'h20;
    while (ng < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_ack1 || ld_ack1) begin
        n_chk++;
        if (mem_ack1 && ld_ack1) begin
          n_fail++; $display("FAIL arb_dual_ack: got both acks want one");
        end
        grants[ng] = mem_ack1 ? 0 : 1;
        ng++;
      end
    end
    mem_req = 1'b0; ld_req = 1'b0;
    n_chk++;
    if (ng != 4) begin
      n_fail++; $display("FAIL arb_timeout: got %0d grants want 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      n_chk++;
      if (grants[i] != exp_g) begin
        n_fail++; $display("FAIL arb_grant%0d: got %0d want %0d (0=MEM 1=LD)", i, grants[i], exp_g);
      end
    end
    idle(8);
  endtask

  task automatic test_req_drop;
    ld_req = 1'b1; ld_write = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h5A;
    @(negedge clk);
    n_chk++;
    if ({dm_we1, dm_addr1, dm_wdata1} !== {1'b1, 32'h20, 32'h5A}) begin
      n_fail++; $display("FAIL drop_t1: got we%b a%h d%h want 1 20 5a", dm_we1, dm_addr1, dm_wdata1);
    end
    ld_req = 1'b0; ld_addr = 32'h30; ld_wdata = 32'hFFFF;
    @(negedge clk);
    n_chk++;
    if ({ld_ack1, dm_we1} !== 2'b10) begin
      n_fail++; $display("FAIL drop_ack: got ack%b we%b want 1 0", ld_ack1, dm_we1);
    end
    idle(8);
    n_chk++;
    if (mem1[8] !== 32'h5A) begin
      n_fail++; $display("FAIL drop_mem: got %h want 5a", mem1[8]);
    end
    ld_req = 1'b1; ld_write = 1'b0; ld_addr = 32'h20;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({ld_ack1, ld_rdata1} !== {1'b1, 32'h5A}) begin
      n_fail++; $display("FAIL drop_readback: got ack%b %h want 1 5a", ld_ack1, ld_rdata1);
    end
    idle(8);
  endtask

  task automatic test_reset_mid;
    int bad_acks = 0;
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h10;
    @(negedge clk);
    n_chk++;
    if (dm_rd3 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got rd%b want 1", dm_rd3);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({dm_rd3, dm_we3, dm_rd1, dm_we1} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_strobe: got %b want 0000", {dm_rd3, dm_we3, dm_rd1, dm_we1});
    end
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ack3 || mem_ack1) bad_acks++;
    end
    n_chk++;
    if (bad_acks != 0) begin
      n_fail++; $display("FAIL rstmid_noack: got %0d ack cycles want 0", bad_acks);
    end
    mem_req = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({mem_ack3, mem_rdata3} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rstmid_after: got ack%b %h want 1 deadbeef", mem_ack3, mem_rdata3);
    end
    idle(8);
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_wait3;
    test_arbitration;
    test_req_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
